// File: rtl/seg_display_if.sv
// Bus between the digit-rotation logic and the seven-segment driver.
// The master side supplies select, digit data and load; the slave side drives the display pins.
interface seg_display_if #(
  parameter int NUM_DIGITS = 5,
  parameter int SEL_W      = 3
);
  logic [SEL_W-1:0]        digit_sel;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    load;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic [6:0]              seg_n;
  logic                    frame_start;

  modport master (
    output digit_sel, digits_in, blink_mask, load,
    input  anode_n, seg_n, frame_start
  );

  modport slave (
    input  digit_sel, digits_in, blink_mask, load,
    output anode_n, seg_n, frame_start
  );
endinterface

// File: rtl/seg_display_driver.sv
// Multiplexed common-anode seven-segment driver: frame-synchronous double buffering,
// anti-ghost blanking on every select change and per-digit blinking.
module seg_hex7 (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg_n
);
  always_comb begin
    o_seg_n = 7'h7F;
    case (i_val)
      4'h0: o_seg_n = 7'h40;
      4'h1: o_seg_n = 7'h79;
      4'h2: o_seg_n = 7'h24;
      4'h3: o_seg_n = 7'h30;
      4'h4: o_seg_n = 7'h19;
      4'h5: o_seg_n = 7'h12;
      4'h6: o_seg_n = 7'h02;
      4'h7: o_seg_n = 7'h78;
      4'h8: o_seg_n = 7'h00;
      4'h9: o_seg_n = 7'h10;
      4'hA: o_seg_n = 7'h08;
      4'hB: o_seg_n = 7'h03;
      4'hC: o_seg_n = 7'h46;
      4'hD: o_seg_n = 7'h21;
      4'hE: o_seg_n = 7'h06;
      4'hF: o_seg_n = 7'h0E;
      default: o_seg_n = 7'h7F;
    endcase
  end
endmodule

module seg_display_driver #(
  parameter int NUM_DIGITS   = 5,
  parameter int SEL_W        = 3,
  parameter int BLANK_CYCLES = 250,
  parameter int BLINK_FRAMES = 30
) (
  input logic         clk,
  input logic         reset_n,
  seg_display_if.slave bus
);
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      blink;
  } buf_t;

  logic [SEL_W-1:0]      r_sel_q;
  logic [BW-1:0]         r_blank_cnt;
  logic [FW-1:0]         r_frame_cnt;
  logic [NUM_DIGITS-1:0] r_anode_n;
  logic [6:0]            r_seg_n;
  logic                  r_frame_start;
  buf_t                  r_act, r_pend;
  logic                  r_pend_vld;

  buf_t                        w_in;
  logic                        w_chg, w_bnd;
  logic [NUM_DIGITS-1:0][6:0]  w_dec;
  logic [6:0]                  w_seg_sel;
  logic [NUM_DIGITS-1:0]       w_an_sel;
  logic                        w_sel_ok, w_blink_sel, w_blink_off, w_lit;

  assign w_in  = {bus.digits_in, bus.blink_mask};
  assign w_chg = (bus.digit_sel != r_sel_q);
  // Only a 4->0 style wrap counts; returning to 0 from an out-of-range select does not.
  assign w_bnd = w_chg && (r_sel_q == SEL_W'(NUM_DIGITS - 1)) && (bus.digit_sel == '0);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    seg_hex7 u_hex (.i_val(r_act.dig[gi]), .o_seg_n(w_dec[gi]));
  end

  always_comb begin
    w_seg_sel   = 7'h7F;
    w_an_sel    = '1;
    w_blink_sel = 1'b0;
    w_sel_ok    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel_q == SEL_W'(i)) begin
        w_seg_sel   = w_dec[i];
        w_an_sel    = ~(NUM_DIGITS'(1) << i);
        w_blink_sel = r_act.blink[i];
        w_sel_ok    = 1'b1;
      end
    end
  end

  assign w_blink_off = w_blink_sel && (r_frame_cnt >= FW'(BLINK_FRAMES));
  assign w_lit       = w_sel_ok && !w_blink_off;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_q       <= '0;
      r_blank_cnt   <= BW'(BLANK_CYCLES);
      r_anode_n     <= '1;
      r_seg_n       <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_bnd;
      if (w_chg) begin
        r_sel_q     <= bus.digit_sel;
        r_blank_cnt <= BW'(BLANK_CYCLES);
        r_anode_n   <= '1;
        r_seg_n     <= '1;
      end else if (r_blank_cnt != '0) begin
        r_blank_cnt <= r_blank_cnt - BW'(1);
        r_anode_n   <= '1;
        r_seg_n     <= '1;
      end else begin
        r_anode_n <= w_lit ? w_an_sel  : '1;
        r_seg_n   <= w_lit ? w_seg_sel : 7'h7F;
      end
    end
  end

  // On a boundary the active buffer takes the pending contents as they were before this edge;
  // a simultaneous load refills pending for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act       <= '0;
      r_pend      <= '0;
      r_pend_vld  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_bnd) begin
        r_frame_cnt <= (r_frame_cnt == FW'(2 * BLINK_FRAMES - 1)) ? '0 : r_frame_cnt + FW'(1);
        if (r_pend_vld) r_act <= r_pend;
      end
      if (bus.load) begin
        r_pend     <= w_in;
        r_pend_vld <= 1'b1;
      end else if (w_bnd) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign bus.anode_n     = r_anode_n;
  assign bus.seg_n       = r_seg_n;
  assign bus.frame_start = r_frame_start;
endmodule
